// File: rtl/flag_branch_unit_pkg.sv
// Shared constants for the flag/branch unit: condition codes, ALU opcodes,
// flag bit positions, FSM states and the per-opcode flag write mask.
package flag_branch_unit_pkg;

    localparam int unsigned FLAG_W = 3;
    localparam int unsigned COND_W = 3;
    localparam int unsigned OP_W   = 4;

    localparam int unsigned FLAG_N = 2;
    localparam int unsigned FLAG_Z = 1;
    localparam int unsigned FLAG_V = 0;

    localparam logic [COND_W-1:0] CC_NE     = 3'd0;
    localparam logic [COND_W-1:0] CC_EQ     = 3'd1;
    localparam logic [COND_W-1:0] CC_GT     = 3'd2;
    localparam logic [COND_W-1:0] CC_LT     = 3'd3;
    localparam logic [COND_W-1:0] CC_GE     = 3'd4;
    localparam logic [COND_W-1:0] CC_LE     = 3'd5;
    localparam logic [COND_W-1:0] CC_OV     = 3'd6;
    localparam logic [COND_W-1:0] CC_UNCOND = 3'd7;

    localparam logic [OP_W-1:0] OP_ADD = 4'h0;
    localparam logic [OP_W-1:0] OP_SUB = 4'h1;
    localparam logic [OP_W-1:0] OP_AND = 4'h2;
    localparam logic [OP_W-1:0] OP_OR  = 4'h3;
    localparam logic [OP_W-1:0] OP_XOR = 4'h4;
    localparam logic [OP_W-1:0] OP_SHL = 4'h5;
    localparam logic [OP_W-1:0] OP_SHR = 4'h6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Which {N,Z,V} bits an ALU writeback of this opcode is allowed to change.
    function automatic logic [FLAG_W-1:0] flag_mask(input logic [OP_W-1:0] op);
        logic [FLAG_W-1:0] m;
        m = '0;
        case (op)
            OP_ADD, OP_SUB:                         m = '1;
            OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR:  m[FLAG_Z] = 1'b1;
            default:                                m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/flag_branch_unit_cond_eval.sv
// Combinational branch condition evaluation over {N,Z,V}.
module branch_cond_eval
    import flag_branch_unit_pkg::*;
(
    input  logic [COND_W-1:0] cond,
    input  logic [FLAG_W-1:0] flags,
    output logic              taken_c
);

    logic n, z, v;
    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign v = flags[FLAG_V];

    always_comb begin
        taken_c = 1'b0;
        case (cond)
            CC_NE:     taken_c = ~z;
            CC_EQ:     taken_c = z;
            CC_GT:     taken_c = ~z & ~n;
            CC_LT:     taken_c = n;
            CC_GE:     taken_c = z | ~n;
            CC_LE:     taken_c = n | z;
            CC_OV:     taken_c = v;
            CC_UNCOND: taken_c = 1'b1;
            default:   taken_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/flag_branch_unit.sv
// Architectural N/Z/V flag register plus branch resolver that waits for
// in-flight flag writers, with same-cycle writeback bypass into evaluation.
module flag_branch_unit
    import flag_branch_unit_pkg::*;
#(
    parameter int unsigned PEND_W = 3,
    parameter int unsigned PC_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pend_set,
    input  logic              flag_wr_en,
    input  logic [OP_W-1:0]   flag_op,
    input  logic [FLAG_W-1:0] flag_in,
    input  logic              flush,
    input  logic              br_valid,
    output logic              br_ready,
    input  logic [COND_W-1:0] br_cond,
    input  logic [PC_W-1:0]   br_target,
    input  logic [PC_W-1:0]   br_pc_inc,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              res_taken,
    output logic [PC_W-1:0]   res_next_pc,
    output logic [FLAG_W-1:0] flags_q,
    output logic              pend_err
);

    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    state_t            state_q, state_d;
    logic [PEND_W-1:0] pend_q, next_pend;
    logic              ovf_c;
    logic [FLAG_W-1:0] mask_c, next_flags;
    logic [COND_W-1:0] cond_q, cond_sel_c;
    logic [PC_W-1:0]   target_q, pc_inc_q, target_sel_c, pc_inc_sel_c;
    logic              cap_c, load_res_c, taken_c;

    // Post-writeback flag value, used both for the register and for evaluation.
    assign mask_c     = flag_wr_en ? flag_mask(flag_op) : '0;
    assign next_flags = (flags_q & ~mask_c) | (flag_in & mask_c);

    // Saturating in-flight writer count; simultaneous issue and retire cancel.
    always_comb begin
        next_pend = pend_q;
        ovf_c     = 1'b0;
        if (pend_set && !flag_wr_en) begin
            if (pend_q == PEND_MAX) ovf_c = 1'b1;
            else                    next_pend = pend_q + PEND_W'(1);
        end else if (flag_wr_en && !pend_set && pend_q != '0) begin
            next_pend = pend_q - PEND_W'(1);
        end
    end

    // In IDLE the live request is evaluated; in WAIT the captured one.
    assign cond_sel_c   = (state_q == ST_IDLE) ? br_cond   : cond_q;
    assign target_sel_c = (state_q == ST_IDLE) ? br_target : target_q;
    assign pc_inc_sel_c = (state_q == ST_IDLE) ? br_pc_inc : pc_inc_q;

    branch_cond_eval u_cond_eval (
        .cond    (cond_sel_c),
        .flags   (next_flags),
        .taken_c (taken_c)
    );

    always_comb begin
        state_d    = state_q;
        cap_c      = 1'b0;
        load_res_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (br_valid) begin
                    cap_c = 1'b1;
                    if (next_pend == '0 || br_cond == CC_UNCOND) begin
                        load_res_c = 1'b1;
                        state_d    = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (next_pend == '0) begin
                    load_res_c = 1'b1;
                    state_d    = ST_RESP;
                end
            end
            ST_RESP: begin
                if (res_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // Flush beats everything, including a request presented this cycle.
        if (flush) begin
            state_d    = ST_IDLE;
            cap_c      = 1'b0;
            load_res_c = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            flags_q     <= '0;
            pend_q      <= '0;
            pend_err    <= 1'b0;
            br_ready    <= 1'b1;
            res_valid   <= 1'b0;
            res_taken   <= 1'b0;
            res_next_pc <= '0;
            cond_q      <= '0;
            target_q    <= '0;
            pc_inc_q    <= '0;
        end else begin
            state_q   <= state_d;
            flags_q   <= next_flags;
            pend_q    <= next_pend;
            pend_err  <= pend_err | ovf_c;
            br_ready  <= (state_d == ST_IDLE);
            res_valid <= (state_d == ST_RESP);
            if (cap_c) begin
                cond_q   <= br_cond;
                target_q <= br_target;
                pc_inc_q <= br_pc_inc;
            end
            if (load_res_c) begin
                res_taken   <= taken_c;
                res_next_pc <= taken_c ? target_sel_c : pc_inc_sel_c;
            end
        end
    end

endmodule
